// File: rtl/piso_serializer_if.sv
// Word-input handshake bundle for the serializer.
// The producer uses the master modport and the serializer uses the slave modport.
interface piso_serializer_if #(
    parameter int N = 8
);
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out feeder for a downstream shift-register chain.
// It accepts N-bit words over a valid/ready handshake and sends one bit every DIV
// cycles, with a one-cycle strobe for the downstream register's enable.
// While the last bit's strobe is active it can accept the next word, so back-to-back
// words leave no gap between them.
module piso_serializer #(
    parameter int N         = 8,
    parameter int DIV       = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    piso_serializer_if.slave   s_in,
    output logic               o_out,
    output logic               o_out_ena,
    output logic               o_busy,
    output logic               o_done
);

    localparam int BCW = $clog2(N + 1);
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(N - 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_buf;
    logic [BCW-1:0] r_bit_cnt;
    logic [DCW-1:0] r_div_cnt;

    logic w_strobe;
    logic w_last;
    logic w_ready;
    logic w_xfer;
    logic w_head;

    // The outputs decode registered state directly. An asynchronous reset
    // therefore clears them at once, without waiting for a clock edge.
    assign w_strobe = (r_state == ST_SHIFT) && (r_div_cnt == DIV_LAST);
    assign w_last   = w_strobe && (r_bit_cnt == BIT_LAST);
    assign w_ready  = i_rst_n && ((r_state == ST_IDLE) || w_last);
    assign w_xfer   = s_in.in_valid && w_ready;
    assign w_head   = (MSB_FIRST != 0) ? r_buf[N-1] : r_buf[0];

    assign s_in.in_ready = w_ready;
    assign o_out         = (r_state == ST_SHIFT) && w_head;
    assign o_out_ena     = w_strobe;
    assign o_busy        = (r_state == ST_SHIFT);
    assign o_done        = w_last;

    // Handshake capture, bit-period divider, bit counter and shift of the buffer
    // toward the output end.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_buf     <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_state   <= ST_SHIFT;
                        r_buf     <= s_in.in_data;
                        r_bit_cnt <= '0;
                        r_div_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_xfer) begin
                        // A transfer can only happen on the last-bit strobe.
                        // Reload the buffer so the next word follows with no gap.
                        r_buf     <= s_in.in_data;
                        r_bit_cnt <= '0;
                        r_div_cnt <= '0;
                    end else if (w_last) begin
                        r_state   <= ST_IDLE;
                        r_bit_cnt <= '0;
                        r_div_cnt <= '0;
                    end else if (w_strobe) begin
                        r_buf     <= (MSB_FIRST != 0) ? (r_buf << 1) : (r_buf >> 1);
                        r_bit_cnt <= r_bit_cnt + BCW'(1);
                        r_div_cnt <= '0;
                    end else begin
                        r_div_cnt <= r_div_cnt + DCW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
